alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
- Packet-level controller between a UART receiver stream and a UART transmitter stream on the board's serial link.
- Parses incoming byte packets and sequences the response onto the transmit stream:
  - echo: payload forwarded unchanged
  - arithmetic: a 32-bit accumulate or product, returned as 4 bytes
- Owns the ready/valid handshakes on both byte streams. The receiver and transmitter instances stay unchanged.

Parameters:
- DATA_WIDTH_P, 8: byte width of rx/tx streams. Only 8 is supported; elaboration error otherwise.
- OPERAND_WIDTH_P, 32: operand/result width. Must be a multiple of DATA_WIDTH_P.
- MAX_LEN_P, 1024: largest legal packet length field, in bytes, header included.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- rx_data_i  in  DATA_WIDTH_P  byte from receiver
- rx_valid_i  in  1  receiver byte valid
- rx_ready_o  out  1  controller accepts byte
- tx_data_o  out  DATA_WIDTH_P  byte to transmitter
- tx_valid_o  out  1  byte valid to transmitter
- tx_ready_i  in  1  transmitter accepts byte
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  one-cycle pulse on a protocol error

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_ni; all state registers clear immediately on assertion.
- Values during reset: rx_ready_o=0, tx_valid_o=0, tx_data_o=0, busy_o=0, err_o=0, FSM=IDLE.
- Handshakes: a transfer occurs on a cycle with valid&ready. tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0.
- Packet format:
  - byte0: opcode
  - byte1: reserved, ignored
  - bytes2-3: LEN, little-endian, counting the whole packet
  - bytes 4..LEN-1: payload
- Opcodes: 0xEC echo, 0xA5 add, 0xB6 mul. All others illegal.
- IDLE: rx_ready_o=1. The first accepted byte goes to HDR as byte0.
- HDR: rx_ready_o=1. Collect bytes1-3, then check the header:
  - LEN<4, LEN>MAX_LEN_P, or illegal opcode: pulse err_o, go to DRAIN.
  - LEN==4: echo returns to IDLE; add/mul go to SEND.
  - Otherwise: echo goes to ECHO; add/mul go to OPND.
- ECHO: combinational pass-through, zero latency.
  - tx_data_o=rx_data_i, tx_valid_o=rx_valid_i, rx_ready_o=tx_ready_i.
  - Count LEN-4 transfers, then go to IDLE.
- OPND: rx_ready_o=1, except while the multiplier is busy.
  - Bytes are assembled little-endian into a 32-bit operand.
  - On the 4th byte, or the final packet byte (partial operand, zero-extended upper bytes), the operand is applied:
    - add: acc <= acc + op, modulo 2^32.
    - mul: starts the sub-multiplier (acc*op, low 32 bits); rx_ready_o=0 until it completes.
  - After the last byte is applied, go to SEND.
- Accumulator initial value: add starts at 0, mul at 1. With no operands, add returns 0x00000000 and mul returns 0x00000001.
- SEND: tx_valid_o=1; the 4 result bytes go out LSB first, then IDLE. rx_ready_o=0.
- DRAIN: rx_ready_o=1. Discard the remaining bytes of the packet and go to IDLE.
  - If LEN<4, nothing further is discarded.
  - Byte counting uses the raw LEN value (up to 65535).
- Byte counter: 16 bits, wraps never, since LEN is bounded by 16 bits.
- Mid-packet reset: reset asserted anywhere clears everything. Bytes received afterwards are parsed as a new packet.
- Simultaneous events: in ECHO, rx and tx handshakes occur on the same cycle by construction. No other state drives both streams.

Optional Feature:
- ALU_CTRL_DIV_EN defined:
  - Adds opcode 0xC7, unsigned divide.
  - The first operand is the dividend; each later operand divides the accumulator.
  - Implemented by an iterative restoring divider of 32 cycles.
  - Division by 0 yields 0xFFFFFFFF and pulses err_o; the packet continues.
- ALU_CTRL_DIV_EN undefined: 0xC7 is illegal (err_o pulse, DRAIN).

Decomposition:
- Package alu_ctrl_pkg:
  - opcode enum (ECHO=8'hEC, ADD=8'hA5, MUL=8'hB6, DIV=8'hC7)
  - state enum (IDLE, HDR, ECHO, OPND, SEND, DRAIN)
  - HDR_BYTES=4
- Sub-module alu_ctrl_mul: iterative shift-add multiplier.
  - Handshake start_i/done_o; 32 cycles.
  - Keeps only the low 32 bits.

Test Plan:
- Echo: EC 00 07 00 11 22 33 -> tx emits 11 22 33 in order. busy_o drops after the third tx handshake.
- Add: A5 00 0C 00 | 01 00 00 00 | FF FF FF FF -> tx 00 00 00 00 (wrap to 0).
- Mul: B6 00 0C 00 | 03 00 00 00 | 05 00 00 00 -> tx 0F 00 00 00. rx_ready_o low for 32 cycles after each operand.
- Partial operand: A5 00 06 00 34 12 -> tx 34 12 00 00.
- Errors:
  - 5A 00 06 00 AA BB -> err_o pulse, no tx, IDLE after 6 bytes.
  - LEN=0x0002 -> err_o pulse, IDLE.
- Backpressure and reset:
  - Echo with tx_ready_i toggling every cycle: no byte lost or duplicated.
  - reset_ni asserted mid-SEND: tx_valid_o=0 immediately; next packet processed normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl shared opcodes, FSM states and header constants.
// Macro ALU_CTRL_DIV_EN makes the divide opcode legal.
package alu_ctrl_pkg;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hA5,
    OP_MUL  = 8'hB6,
    OP_DIV  = 8'hC7
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ECHO,
    S_OPND,
    S_SEND,
    S_DRAIN
  } state_e;

  localparam int HDR_BYTES = 4;

  function automatic logic op_legal(input logic [7:0] op);
    logic ok;
    ok = (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL);
`ifdef ALU_CTRL_DIV_EN
    ok = ok || (op == OP_DIV);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/alu_ctrl_mul.sv
// Iterative shift-add multiplier, one operand bit per cycle.
// Only the low W bits of the product are kept.
module alu_ctrl_mul #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] p_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  p_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  p_next;

  assign p_next = b_q[0] ? p_q + a_q : p_q;
  // done fires on the final iteration so the result is usable at once
  assign done_o = busy_o && (cnt_q == CW'(1));
  assign p_o    = p_next;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_o <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      p_q    <= '0;
      cnt_q  <= CW'(W);
      busy_o <= 1'b1;
    end else if (busy_o) begin
      p_q   <= p_next;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_o <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl.sv
// Packet controller between UART rx and tx byte streams: echo, add, mul.
// Macro ALU_CTRL_DIV_EN adds opcode 0xC7 (restoring divide).
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH_P    = 8,
  parameter int OPERAND_WIDTH_P = 32,
  parameter int MAX_LEN_P       = 1024
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [DATA_WIDTH_P-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic [DATA_WIDTH_P-1:0] tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int W  = OPERAND_WIDTH_P;
  localparam int NB = OPERAND_WIDTH_P / DATA_WIDTH_P;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [15:0] HDR_W = 16'(HDR_BYTES);
  localparam logic [15:0] MAX_W = 16'(MAX_LEN_P);

  if (DATA_WIDTH_P != 8) begin : g_dw_chk
    $error("alu_ctrl: DATA_WIDTH_P must be 8");
  end
  if (OPERAND_WIDTH_P % DATA_WIDTH_P != 0) begin : g_ow_chk
    $error("alu_ctrl: OPERAND_WIDTH_P must be a multiple of DATA_WIDTH_P");
  end

  state_e      state_q;
  logic        run_q;
  logic [7:0]  op_q;
  logic [15:0] cnt_q;
  logic [15:0] len_q;
  logic [BW-1:0] bidx_q;
  logic [BW-1:0] sidx_q;
  logic [W-1:0]  opbuf_q;
  logic [W-1:0]  acc_q;
  logic        pend_last_q;
  logic        err_q;

  logic        rx_hs;
  logic        tx_hs;
  logic        opnd_hs;
  logic        last;
  logic        apply;
  logic [15:0] len_full;
  logic        hdr_bad;
  logic [W-1:0] op_next;
  logic        is_add;
  logic        is_mul;

  logic         mul_start;
  logic         mul_busy;
  logic         mul_done;
  logic [W-1:0] mul_p;
  logic         div_busy;
  logic         div_done;
  logic [W-1:0] div_res;

  assign rx_hs    = rx_valid_i & rx_ready_o;
  assign tx_hs    = tx_valid_o & tx_ready_i;
  assign opnd_hs  = (state_q == S_OPND) & rx_hs;
  assign last     = (cnt_q == len_q - 16'd1);
  assign apply    = (bidx_q == BW'(NB - 1)) | last;
  assign len_full = {rx_data_i, len_q[7:0]};
  assign hdr_bad  = !op_legal(op_q) || (len_full < HDR_W) || (len_full > MAX_W);
  assign op_next  = opbuf_q | (W'(rx_data_i) << (DATA_WIDTH_P * int'(bidx_q)));
  assign is_add   = (op_q == OP_ADD);
  assign is_mul   = (op_q == OP_MUL);
  assign mul_start = opnd_hs & apply & is_mul;
  assign busy_o   = (state_q != S_IDLE);
  assign err_o    = err_q;

  alu_ctrl_mul #(
    .W(W)
  ) u_mul (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .start_i (mul_start),
    .a_i     (acc_q),
    .b_i     (op_next),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

`ifdef ALU_CTRL_DIV_EN
  localparam int CW = $clog2(W + 1);

  logic          is_div;
  logic          first_q;
  logic          div_start;
  logic [CW-1:0] div_cnt_q;
  logic [W-1:0]  div_rem_q;
  logic [W-1:0]  div_quo_q;
  logic [W-1:0]  div_den_q;
  logic [W:0]    div_sh;
  logic [W:0]    div_trial;

  assign is_div    = (op_q == OP_DIV);
  assign div_start = opnd_hs & apply & is_div & !first_q & (op_next != '0);
  assign div_sh    = {div_rem_q, div_quo_q[W-1]};
  assign div_trial = div_sh - {1'b0, div_den_q};
  assign div_res   = {div_quo_q[W-2:0], !div_trial[W]};
  assign div_done  = div_busy && (div_cnt_q == CW'(1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_busy  <= 1'b0;
      div_cnt_q <= '0;
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_den_q <= '0;
    end else if (div_start) begin
      div_busy  <= 1'b1;
      div_cnt_q <= CW'(W);
      div_rem_q <= '0;
      div_quo_q <= acc_q;
      div_den_q <= op_next;
    end else if (div_busy) begin
      div_rem_q <= div_trial[W] ? div_sh[W-1:0] : div_trial[W-1:0];
      div_quo_q <= div_res;
      div_cnt_q <= div_cnt_q - CW'(1);
      if (div_cnt_q == CW'(1)) div_busy <= 1'b0;
    end
  end
`else
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    unique case (state_q)
      S_IDLE, S_HDR, S_DRAIN: rx_ready_o = run_q;
      S_ECHO: begin
        tx_data_o  = rx_data_i;
        tx_valid_o = rx_valid_i;
        rx_ready_o = tx_ready_i;
      end
      S_OPND: rx_ready_o = !(mul_busy | div_busy | pend_last_q);
      S_SEND: begin
        tx_valid_o = 1'b1;
        tx_data_o  = acc_q[int'(sidx_q) * DATA_WIDTH_P +: DATA_WIDTH_P];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      op_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      bidx_q      <= '0;
      sidx_q      <= '0;
      opbuf_q     <= '0;
      acc_q       <= '0;
      pend_last_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_CTRL_DIV_EN
      first_q     <= 1'b0;
`endif
    end else begin
      run_q <= 1'b1;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (rx_hs) begin
          op_q    <= rx_data_i;
          cnt_q   <= 16'd1;
          state_q <= S_HDR;
        end
        S_HDR: if (rx_hs) begin
          cnt_q <= cnt_q + 16'd1;
          if (cnt_q == HDR_W - 16'd2) len_q[7:0] <= rx_data_i;
          if (cnt_q == HDR_W - 16'd1) begin
            len_q       <= len_full;
            bidx_q      <= '0;
            sidx_q      <= '0;
            opbuf_q     <= '0;
            pend_last_q <= 1'b0;
            acc_q       <= is_mul ? W'(1) : '0;
`ifdef ALU_CTRL_DIV_EN
            first_q     <= 1'b1;
`endif
            if (hdr_bad) begin
              err_q   <= 1'b1;
              // nothing left to discard when LEN covers only the header
              state_q <= (len_full > HDR_W) ? S_DRAIN : S_IDLE;
            end else if (len_full == HDR_W) begin
              state_q <= (op_q == OP_ECHO) ? S_IDLE : S_SEND;
            end else begin
              state_q <= (op_q == OP_ECHO) ? S_ECHO : S_OPND;
            end
          end
        end
        S_ECHO: if (rx_hs) begin
          cnt_q <= cnt_q + 16'd1;
          if (last) state_q <= S_IDLE;
        end
        S_OPND: begin
          if (mul_done | div_done) begin
            acc_q <= mul_done ? mul_p : div_res;
            if (pend_last_q) begin
              pend_last_q <= 1'b0;
              state_q     <= S_SEND;
            end
          end
          if (rx_hs) begin
            cnt_q   <= cnt_q + 16'd1;
            bidx_q  <= apply ? '0 : bidx_q + BW'(1);
            opbuf_q <= apply ? '0 : op_next;
            if (apply) begin
              unique case (1'b1)
                is_add: begin
                  acc_q <= acc_q + op_next;
                  if (last) state_q <= S_SEND;
                end
                is_mul: pend_last_q <= last;
`ifdef ALU_CTRL_DIV_EN
                is_div: begin
                  first_q <= 1'b0;
                  if (first_q || op_next == '0) begin
                    acc_q <= first_q ? op_next : '1;
                    err_q <= !first_q;
                    if (last) state_q <= S_SEND;
                  end else begin
                    pend_last_q <= last;
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        end
        S_SEND: if (tx_hs) begin
          sidx_q <= sidx_q + BW'(1);
          if (sidx_q == BW'(NB - 1)) state_q <= S_IDLE;
        end
        S_DRAIN: if (rx_hs) begin
          cnt_q <= cnt_q + 16'd1;
          if (last) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed packets plus random
// packets scored against a packet-level reference model.
module tb_alu_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b1;
  logic       busy_o;
  logic       err_o;

  int checks = 0;
  int failures = 0;

  int txr_mode = 0;
  logic [7:0] pkt[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int exp_err;
  int err_cnt = 0;
  int stab_viol = 0;
  int runs[$];
  int lowrun = 0;

  alu_ctrl dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .rx_data_i (rx_data_i),
    .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o),
    .tx_data_o (tx_data_o),
    .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready_i),
    .busy_o    (busy_o),
    .err_o     (err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial forever begin
    @(posedge clk_i);
    #1;
    case (txr_mode)
      0: tx_ready_i = 1'b1;
      1: tx_ready_i = !tx_ready_i;
      2: tx_ready_i = 1'($urandom_range(0, 1));
      default: tx_ready_i = 1'b0;
    endcase
  end

  // mid-cycle monitor: handshakes seen here complete at the next edge
  initial begin
    logic stall;
    logic [7:0] stall_d;
    stall = 1'b0;
    stall_d = 8'h00;
    forever begin
      @(negedge clk_i);
      if (reset_ni) begin
        if (tx_valid_o && tx_ready_i) got_q.push_back(tx_data_o);
        if (err_o) err_cnt++;
        if (stall && !(tx_valid_o && tx_data_o == stall_d)) stab_viol++;
        stall = tx_valid_o && !tx_ready_i;
        stall_d = tx_data_o;
        if (busy_o && !rx_ready_o && !tx_valid_o) lowrun++;
        else if (lowrun != 0) begin
          runs.push_back(lowrun);
          lowrun = 0;
        end
      end else begin
        stall = 1'b0;
        lowrun = 0;
      end
    end
  end

  task automatic model();
    logic [7:0] opc;
    logic [15:0] len;
    logic [31:0] acc;
    logic [31:0] opnd;
    bit legal;
    bit first;
    exp_q.delete();
    exp_err = 0;
    opc = pkt[0];
    len = {pkt[3], pkt[2]};
    legal = (opc == 8'hEC) || (opc == 8'hA5) || (opc == 8'hB6);
`ifdef ALU_CTRL_DIV_EN
    legal = legal || (opc == 8'hC7);
`endif
    if (!legal || len < 16'd4 || int'(len) > 1024) begin
      exp_err = 1;
      return;
    end
    if (opc == 8'hEC) begin
      for (int i = 4; i < int'(len); i++) exp_q.push_back(pkt[i]);
      return;
    end
    acc = (opc == 8'hB6) ? 32'd1 : 32'd0;
    first = 1'b1;
    for (int i = 4; i < int'(len); i += 4) begin
      opnd = 32'd0;
      for (int k = 0; k < 4 && i + k < int'(len); k++)
        opnd = opnd | (32'(pkt[i+k]) << (8 * k));
      if (opc == 8'hA5) acc = acc + opnd;
      else if (opc == 8'hB6) acc = 32'(64'(acc) * 64'(opnd));
      else begin
        if (first) acc = opnd;
        else if (opnd == 32'd0) begin
          acc = 32'hFFFF_FFFF;
          exp_err++;
        end else acc = acc / opnd;
        first = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(acc >> (8 * k)));
  endtask

  task automatic make_pkt(input logic [7:0] opc, input logic [15:0] len);
    int n;
    pkt.delete();
    pkt.push_back(opc);
    pkt.push_back(8'($urandom));
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    n = (len < 16'd4) ? 4 : int'(len);
    for (int i = 4; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  function automatic string fmt_q(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) if (i < 40) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic int q_diff();
    int d;
    d = (got_q.size() != exp_q.size()) ? 1 : 0;
    if (d == 0) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic drive_pkt(input bit gaps);
    int i;
    int guard;
    bit took;
    i = 0;
    guard = 0;
    took = 1'b0;
    while (guard < 20000) begin
      @(posedge clk_i);
      #1;
      if (took) begin
        i++;
        took = 1'b0;
        rx_valid_i = 1'b0;
      end
      if (i >= pkt.size()) break;
      if (!rx_valid_i) rx_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rx_data_i = pkt[i];
      @(negedge clk_i);
      took = rx_valid_i && rx_ready_o;
      guard++;
    end
    rx_valid_i = 1'b0;
    if (i < pkt.size()) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout sent=%0d required=%0d", i, pkt.size());
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk_i);
    while (busy_o && g < 5000) begin
      @(negedge clk_i);
      g++;
    end
    if (busy_o) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout busy=%0b required=0", busy_o);
    end
    @(negedge clk_i);
  endtask

  task automatic start_pkt(input int mode);
    txr_mode = mode;
    got_q.delete();
    err_cnt = 0;
    model();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    checks += 5;
    if (rx_ready_o !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready_o); end
    if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid_o); end
    if (tx_data_o !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_echo();
    pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    start_pkt(0);
    drive_pkt(1'b0);
    @(negedge clk_i);
    checks += 2;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL echo_busy_drop got=%b exp=0", busy_o); end
    if (q_diff() != 0) begin failures++; $display("FAIL echo_data got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
    wait_idle();
  endtask

  task automatic test_add();
    pkt = {8'hA5, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start_pkt(0);
    drive_pkt(1'b1);
    wait_idle();
    checks += 2;
    if (q_diff() != 0) begin failures++; $display("FAIL add_wrap got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
    if (err_cnt != 0) begin failures++; $display("FAIL add_err got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_mul();
    pkt = {8'hB6, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
           8'h05, 8'h00, 8'h00, 8'h00};
    start_pkt(0);
    runs.delete();
    drive_pkt(1'b0);
    wait_idle();
    checks += 3;
    if (q_diff() != 0) begin failures++; $display("FAIL mul_data got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
    if (runs.size() != 2) begin failures++; $display("FAIL mul_stall_runs got=%0d exp=2", runs.size()); end
    else if (runs[0] != 32 || runs[1] != 32) begin
      failures++;
      $display("FAIL mul_stall_len got=%0d,%0d exp=32,32", runs[0], runs[1]);
    end
    make_pkt(8'hB6, 16'd4);
    start_pkt(0);
    drive_pkt(1'b0);
    wait_idle();
    checks++;
    if (q_diff() != 0) begin failures++; $display("FAIL mul_empty got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
  endtask

  task automatic test_partial();
    pkt = {8'hA5, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
    start_pkt(0);
    drive_pkt(1'b1);
    wait_idle();
    checks++;
    if (q_diff() != 0) begin failures++; $display("FAIL partial got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
  endtask

  task automatic test_errors();
    pkt = {8'h5A, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    start_pkt(0);
    drive_pkt(1'b0);
    @(negedge clk_i);
    checks += 3;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL badop_idle got=%b exp=0", busy_o); end
    if (err_cnt != 1) begin failures++; $display("FAIL badop_err got=%0d exp=1", err_cnt); end
    if (got_q.size() != 0) begin failures++; $display("FAIL badop_tx got=%0d exp=0", got_q.size()); end
    pkt = {8'hA5, 8'h00, 8'h02, 8'h00};
    start_pkt(0);
    drive_pkt(1'b0);
    @(negedge clk_i);
    checks += 2;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL shortlen_idle got=%b exp=0", busy_o); end
    if (err_cnt != 1) begin failures++; $display("FAIL shortlen_err got=%0d exp=1", err_cnt); end
    make_pkt(8'hEC, 16'd1030);
    start_pkt(0);
    drive_pkt(1'b0);
    @(negedge clk_i);
    checks += 3;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL longlen_idle got=%b exp=0", busy_o); end
    if (err_cnt != 1) begin failures++; $display("FAIL longlen_err got=%0d exp=1", err_cnt); end
    if (got_q.size() != 0) begin failures++; $display("FAIL longlen_tx got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    make_pkt(8'hEC, 16'd16);
    stab_viol = 0;
    start_pkt(1);
    drive_pkt(1'b1);
    wait_idle();
    checks += 2;
    if (q_diff() != 0) begin failures++; $display("FAIL bp_echo got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
    if (stab_viol != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
    make_pkt(8'hA5, 16'd11);
    start_pkt(1);
    drive_pkt(1'b1);
    wait_idle();
    checks += 2;
    if (q_diff() != 0) begin failures++; $display("FAIL bp_send got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
    if (stab_viol != 0) begin failures++; $display("FAIL bp_send_stable got=%0d exp=0", stab_viol); end
  endtask

  task automatic test_reset_mid_send();
    int g;
    pkt = {8'hA5, 8'h00, 8'h04, 8'h00};
    start_pkt(3);
    drive_pkt(1'b0);
    g = 0;
    @(negedge clk_i);
    while (!tx_valid_o && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    checks++;
    if (tx_valid_o !== 1'b1) begin failures++; $display("FAIL send_reach got=%b exp=1", tx_valid_o); end
    #2;
    reset_ni = 1'b0;
    #1;
    checks += 3;
    if (tx_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_tx_valid got=%b exp=0", tx_valid_o); end
    if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    if (rx_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_rx_ready got=%b exp=0", rx_ready_o); end
    @(negedge clk_i);
    reset_ni = 1'b1;
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL midrst_tx got=%0d exp=0", got_q.size()); end
    pkt = {8'hA5, 8'h00, 8'h06, 8'h00, 8'h34, 8'h12};
    start_pkt(0);
    drive_pkt(1'b0);
    wait_idle();
    checks++;
    if (q_diff() != 0) begin failures++; $display("FAIL post_rst got=%s exp=%s", fmt_q(got_q), fmt_q(exp_q)); end
  endtask

  task automatic test_random();
    int r;
    logic [7:0] opc;
    logic [15:0] len;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      if (r < 4) opc = 8'hEC;
      else if (r < 8) opc = 8'hA5;
      else if (r < 12) opc = 8'hB6;
      else if (r < 13) opc = 8'hC7;
      else opc = 8'($urandom);
      if ($urandom_range(0, 9) == 0) len = 16'($urandom_range(0, 3));
      else len = 16'($urandom_range(4, 18));
      make_pkt(opc, len);
      start_pkt(2);
      drive_pkt(1'b1);
      wait_idle();
      checks += 2;
      if (q_diff() != 0) begin
        failures++;
        $display("FAIL rnd_tx pkt=%0d op=%h len=%0d got=%s exp=%s",
                 n, opc, len, fmt_q(got_q), fmt_q(exp_q));
      end
      if (err_cnt != exp_err) begin
        failures++;
        $display("FAIL rnd_err pkt=%0d op=%h len=%0d got=%0d exp=%0d",
                 n, opc, len, err_cnt, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_add();
    test_mul();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_mid_send();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
